// File: rtl/mux_nto1_rr_reg.sv
// N:1 valid/ready channel mux with registered output, fixed-select or round-robin grant.
// Optional MUX_PKT_LOCK_EN: in_last/out_last ports and RR packet locking.
module mux_nto1_rr_reg #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
`ifdef MUX_PKT_LOCK_EN
   input  logic [N-1:0]      in_last,
   output logic              out_last,
`endif
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [SELW:0] NV = (SELW+1)'(N);

   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] rr_g;
   logic [SELW-1:0] g;
   logic            rr_v;
   logic            gnt_v;
   logic            can_acc;
   logic            g_vld;
   logic            g_last;
   logic            xfer;
   logic [W-1:0]    g_data;
   int              best_d;
   int              d;

`ifdef MUX_PKT_LOCK_EN
   logic            lock_q;
   logic [SELW-1:0] lock_g;
`endif

   // Distance from ptr+1 going upward with wrap; smallest valid distance wins
   always_comb begin
      rr_v   = 1'b0;
      rr_g   = '0;
      best_d = N;
      d      = 0;
      for (int i = 0; i < N; i++) begin
         d = (i + N - int'(ptr_q) - 1) % N;
         if (in_valid[i] && d < best_d) begin
            best_d = d;
            rr_g   = SELW'(i);
            rr_v   = 1'b1;
         end
      end
   end

   always_comb begin
      g     = '0;
      gnt_v = 1'b0;
      if (!mode) begin
         g     = sel;
         gnt_v = ({1'b0, sel} < NV);
      end
`ifdef MUX_PKT_LOCK_EN
      else if (lock_q) begin
         g     = lock_g;
         gnt_v = 1'b1;
      end
`endif
      else begin
         g     = rr_g;
         gnt_v = rr_v;
      end
   end

   assign can_acc = !out_valid | out_ready;

   always_comb begin
      in_ready = '0;
      g_data   = '0;
      g_vld    = 1'b0;
      g_last   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (g == SELW'(i)) begin
            in_ready[i] = !rst && gnt_v && can_acc;
            g_data      = in_data[i*W +: W];
            g_vld       = in_valid[i];
`ifdef MUX_PKT_LOCK_EN
            g_last      = in_last[i];
`endif
         end
      end
   end

   assign xfer = gnt_v & can_acc & g_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr_q     <= SELW'(N-1);
`ifdef MUX_PKT_LOCK_EN
         out_last  <= 1'b0;
         lock_q    <= 1'b0;
         lock_g    <= '0;
`endif
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= g_data;
         out_ch    <= g;
         ptr_q     <= g;
`ifdef MUX_PKT_LOCK_EN
         out_last  <= g_last;
         if (mode) begin
            lock_q <= !g_last;
            lock_g <= g;
         end
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Directed bench for mux_nto1_rr_reg: N=4 and N=3 instances, fixed/RR/backpressure/reset.
module tb_mux_nto1_rr_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        mode, out_ready, out_valid;
   logic [1:0]  sel, out_ch;
   logic [31:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [7:0]  out_data;
`ifdef MUX_PKT_LOCK_EN
   logic [3:0]  in_last;
   logic        out_last;
   logic [2:0]  d3_in_last;
   logic        d3_out_last;
`endif

   logic        d3_mode, d3_out_ready, d3_out_valid;
   logic [1:0]  d3_sel, d3_out_ch;
   logic [23:0] d3_in_data;
   logic [2:0]  d3_in_valid, d3_in_ready;
   logic [7:0]  d3_out_data;

   int total = 0;
   int bad   = 0;

   mux_nto1_rr_reg #(.N(4), .W(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_PKT_LOCK_EN
      .in_last(in_last), .out_last(out_last),
`endif
      .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_nto1_rr_reg #(.N(3), .W(8)) dut3 (
      .clk(clk), .rst(rst), .mode(d3_mode), .sel(d3_sel),
      .in_data(d3_in_data), .in_valid(d3_in_valid),
`ifdef MUX_PKT_LOCK_EN
      .in_last(d3_in_last), .out_last(d3_out_last),
`endif
      .in_ready(d3_in_ready), .out_data(d3_out_data), .out_ch(d3_out_ch),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
      in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      in_valid = 4'b1111;
      d3_mode = 1'b0; d3_sel = 2'd0; d3_out_ready = 1'b1;
      d3_in_data = {8'hC2, 8'hB1, 8'hA0};
      d3_in_valid = 3'b000;
`ifdef MUX_PKT_LOCK_EN
      in_last = 4'b0000;
      d3_in_last = 3'b000;
`endif
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_ch", 32'(out_ch), 32'h0);

      // Fixed select
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk("fix_in_ready", 32'(in_ready), 32'(1 << s));
         tick();
         chk("fix_out_valid", 32'(out_valid), 32'h1);
         chk("fix_out_ch", 32'(out_ch), 32'(s));
         chk("fix_out_data", 32'(out_data), 32'(8'hA0 + 8'h11 * s));
      end

      // Round-robin from reset, all valid
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
         tick();
         chk("rr_out_ch", 32'(out_ch), 32'(i % 4));
         chk("rr_out_valid", 32'(out_valid), 32'h1);
      end

      // Only ch1 and ch3 valid
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr13_in_ready", 32'(in_ready), (i % 2) ? 32'h8 : 32'h2);
         tick();
         chk("rr13_out_ch", 32'(out_ch), (i % 2) ? 32'h3 : 32'h1);
         chk("rr13_out_data", 32'(out_data), (i % 2) ? 32'hD3 : 32'hB1);
      end

      // Backpressure while holding ch3
      in_valid = 4'b1111;
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready0", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'h1);
         chk("bp_out_ch", 32'(out_ch), 32'h3);
         chk("bp_out_data", 32'(out_data), 32'hD3);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("rel_out_ch", 32'(out_ch), 32'h0);
      chk("rel_out_data", 32'(out_data), 32'hA0);
      in_valid = 4'b0000;
      tick();
      chk("drain_out_valid", 32'(out_valid), 32'h0);
      chk("drain_out_data", 32'(out_data), 32'hA0);
      chk("drain_out_ch", 32'(out_ch), 32'h0);

      // N=3 out-of-range select, then reset with a held beat
      mode = 1'b0;
      d3_sel = 2'd3;
      d3_in_valid = 3'b111;
      #1;
      chk("n3_sel3_in_ready", 32'(d3_in_ready), 32'h0);
      tick();
      chk("n3_sel3_out_valid", 32'(d3_out_valid), 32'h0);
      d3_sel = 2'd2;
      d3_out_ready = 1'b0;
      tick();
      chk("n3_sel2_out_data", 32'(d3_out_data), 32'hC2);
      chk("n3_sel2_out_valid", 32'(d3_out_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("n3_rst_out_valid", 32'(d3_out_valid), 32'h0);
      chk("n3_rst_in_ready", 32'(d3_in_ready), 32'h0);
      tick();
      rst = 1'b0;
      d3_mode = 1'b1;
      d3_out_ready = 1'b1;
      #1;
      chk("n3_rr_in_ready", 32'(d3_in_ready), 32'h1);
      tick();
      chk("n3_rr_out_ch", 32'(d3_out_ch), 32'h0);
      chk("n3_rr_out_data", 32'(d3_out_data), 32'hA0);
      #1;
      chk("n3_rr_in_ready2", 32'(d3_in_ready), 32'h2);

`ifdef MUX_PKT_LOCK_EN
      // Packet lock: ch2 holds the grant until its last beat
      do_reset();
      mode = 1'b1;
      in_valid = 4'b0100;
      in_last = 4'b0000;
      #1;
      chk("lk_in_ready1", 32'(in_ready), 32'h4);
      tick();
      chk("lk_out_ch1", 32'(out_ch), 32'h2);
      chk("lk_out_last1", 32'(out_last), 32'h0);
      in_valid = 4'b0101;
      #1;
      chk("lk_in_ready2", 32'(in_ready), 32'h4);
      tick();
      chk("lk_out_ch2", 32'(out_ch), 32'h2);
      in_valid = 4'b0001;
      #1;
      chk("lk_in_ready_drop", 32'(in_ready), 32'h4);
      tick();
      chk("lk_gap_out_valid", 32'(out_valid), 32'h0);
      in_valid = 4'b0101;
      in_last = 4'b0100;
      tick();
      chk("lk_out_ch3", 32'(out_ch), 32'h2);
      chk("lk_out_last3", 32'(out_last), 32'h1);
      tick();
      chk("lk_out_ch4", 32'(out_ch), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
